// File: rtl/fifo_pkg.sv
// Shared pointer definitions and Gray-code helpers for the asynchronous FIFO.
// The read/write controllers and the synchronizer bench import this package.
package fifo_pkg;

    localparam int unsigned ADDR_W = 4;

    typedef logic [ADDR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t ptr);
        return (ptr >> 1) ^ ptr;
    endfunction

    // XOR-prefix from the MSB down: each binary bit is the parity of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t ptr);
        ptr_t bin;
        bin = ptr;
        for (int unsigned i = 1; i <= ADDR_W; i++) begin
            bin[ADDR_W-i] = bin[ADDR_W-i+1] ^ ptr[ADDR_W-i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty.sv
// Read-side pointer and empty/almost-empty/level controller of the async FIFO (rclk domain).
// All status outputs are registered and derived from the next read pointer.
module rptr_empty #(
    parameter int unsigned ADDR_W    = fifo_pkg::ADDR_W,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic [ADDR_W:0]   w2r_wptr,
    input  logic              rinc,
    input  logic              runderflow_clr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr,
    output logic              rempty,
    output logic              raempty,
    output logic [ADDR_W:0]   rlevel,
    output logic              runderflow
);

    import fifo_pkg::*;

    typedef logic [ADDR_W:0] rptr_t;

    localparam rptr_t AE_TH = rptr_t'(AEMPTY_TH);

    rptr_t rbin;
    rptr_t rbinnext;
    rptr_t rgraynext;
    rptr_t wbin_s;
    rptr_t level_next;
    logic  pop;

    // Package helpers are sized for the package ADDR_W; casts keep widths explicit.
    always_comb begin
        pop        = rinc & ~rempty;
        rbinnext   = rbin + rptr_t'(pop);
        rgraynext  = rptr_t'(bin2gray(ptr_t'(rbinnext)));
        wbin_s     = rptr_t'(gray2bin(ptr_t'(w2r_wptr)));
        level_next = wbin_s - rbinnext;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            rempty     <= (rgraynext == w2r_wptr);
            raempty    <= (level_next <= AE_TH);
            rlevel     <= level_next;
            // A new underflow takes priority over a coincident clear.
            runderflow <= (rinc & rempty) | (runderflow & ~runderflow_clr);
        end
    end

    assign raddr = rbin[ADDR_W-1:0];

endmodule
